// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic {
    RUN,
    TRAP
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Fetch stage bus: instruction memory port, redirect input and decode handshake.
interface ifetch_if;

  logic [31:0] op_inst_addr;
  logic        ip_inst_valid;
  logic [31:0] ip_inst_from_imem;
  logic        ip_redirect;
  logic [31:0] ip_redirect_pc;
  logic        op_inst_valid;
  logic [31:0] op_inst;
  logic [31:0] op_inst_pc;
  logic        ip_dec_ready;
  logic        op_fetch_misalign;

  modport master (
    output op_inst_addr, op_inst_valid, op_inst, op_inst_pc, op_fetch_misalign,
    input  ip_inst_valid, ip_inst_from_imem, ip_redirect, ip_redirect_pc, ip_dec_ready
  );

  modport slave (
    input  op_inst_addr, op_inst_valid, op_inst, op_inst_pc, op_fetch_misalign,
    output ip_inst_valid, ip_inst_from_imem, ip_redirect, ip_redirect_pc, ip_dec_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// Synchronous FIFO of {pc, inst} entries between fetch and decode.
// Empty head reads as a NOP at PC 0.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [AW:0]  count,
  output logic         head_valid,
  output fetch_entry_t head
);

  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop & head_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_comb begin
    head = '{pc: '0, inst: NOP_INST};
    if (head_valid) head = mem[rd_ptr];
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, imem addressing and output FIFO to decode.
// Optional misaligned-redirect trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
module ifetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic      ip_clk,
  input logic      ip_rst_n,
  ifetch_if.master bus
);

  localparam int unsigned AW      = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(BUF_DEPTH);

  state_t       state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  redirect_tgt;
  logic         fire;
  logic         pop;
  logic [AW:0]  buf_count;
  logic         head_valid;
  fetch_entry_t head;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign redirect_tgt      = bus.ip_redirect_pc;
  assign bus.op_fetch_misalign = (state == TRAP);
`else
  assign redirect_tgt      = bus.ip_redirect_pc & ~32'h3;
  assign bus.op_fetch_misalign = 1'b0;
`endif

  assign pop = head_valid & bus.ip_dec_ready;

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Redirect wins over fetch; a same-cycle pop still completes inside the buffer.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fire      = 1'b0;
    if (bus.ip_redirect) begin
      pc_nxt = redirect_tgt;
`ifdef IFETCH_MISALIGN_TRAP_EN
      state_nxt = (redirect_tgt[1:0] != 2'b00) ? TRAP : RUN;
`endif
    end else if (state == RUN && bus.ip_inst_valid && (buf_count < DEPTH_C || pop)) begin
      fire   = 1'b1;
      pc_nxt = pc + PC_INC;
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (ip_clk),
    .rst_n      (ip_rst_n),
    .push       (fire),
    .pop        (pop),
    .flush      (bus.ip_redirect),
    .din        ('{pc: pc, inst: bus.ip_inst_from_imem}),
    .count      (buf_count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign bus.op_inst_addr  = pc;
  assign bus.op_inst_valid = head_valid;
  assign bus.op_inst       = head.inst;
  assign bus.op_inst_pc    = head.pc;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: queue-based reference model plus negedge monitor.
module tb_ifetch;
  import fetch_pkg::*;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic ip_clk   = 1'b0;
  logic ip_rst_n = 1'b0;

  ifetch_if bus();

  ifetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .ip_clk   (ip_clk),
    .ip_rst_n (ip_rst_n),
    .bus      (bus)
  );

  always #5 ip_clk = ~ip_clk;

  exp_t        exp_q[$];
  logic [31:0] m_pc;
  bit          m_trap;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_pc   = RST_PC;
    m_trap = 1'b0;
  endfunction

  // Effect of one rising edge, from the inputs held during the cycle before it.
  // Any pop for that cycle has already been removed from exp_q by the monitor.
  function automatic void model_edge();
    logic [31:0] tgt;
    exp_t        e;
    tgt = bus.ip_redirect_pc;
    if (!ip_rst_n) begin
      model_reset();
    end else if (bus.ip_redirect) begin
      exp_q.delete();
      if (TRAP_EN) begin
        m_pc   = tgt;
        m_trap = (tgt[1:0] != 2'b00);
      end else begin
        m_pc = {tgt[31:2], 2'b00};
      end
    end else if (!m_trap && bus.ip_inst_valid && exp_q.size() < DEPTH) begin
      e.pc   = m_pc;
      e.inst = bus.ip_inst_from_imem;
      exp_q.push_back(e);
      m_pc = m_pc + 32'd4;
    end
  endfunction

  always @(negedge ip_clk) begin
    chk("inst_addr", bus.op_inst_addr, m_pc);
    chk("inst_valid", 32'(bus.op_inst_valid), 32'(exp_q.size() != 0));
    chk("fetch_misalign", 32'(bus.op_fetch_misalign), 32'(m_trap));
    if (exp_q.size() != 0) begin
      chk("head_pc", bus.op_inst_pc, exp_q[0].pc);
      chk("head_inst", bus.op_inst, exp_q[0].inst);
      if (bus.ip_dec_ready) void'(exp_q.pop_front());
    end else begin
      chk("empty_inst", bus.op_inst, NOP_INST);
      chk("empty_pc", bus.op_inst_pc, 32'h0);
    end
  end

  task automatic cyc(input bit rdy, input bit ivld, input bit redir, input logic [31:0] tgt);
    bus.ip_dec_ready      = rdy;
    bus.ip_inst_valid     = ivld;
    bus.ip_redirect       = redir;
    bus.ip_redirect_pc    = tgt;
    bus.ip_inst_from_imem = $urandom;
    @(posedge ip_clk);
    #1;
    model_edge();
  endtask

  initial begin
    bit          rdy, ivld, redir;
    logic [31:0] tgt;

    bus.ip_dec_ready      = 1'b0;
    bus.ip_inst_valid     = 1'b0;
    bus.ip_redirect       = 1'b0;
    bus.ip_redirect_pc    = '0;
    bus.ip_inst_from_imem = '0;
    model_reset();

    repeat (3) cyc(1, 1, 0, 32'h0);
    ip_rst_n = 1'b1;
    repeat (6) cyc(1, 1, 0, 32'h0);

    // Back-pressure straight out of reset.
    ip_rst_n = 1'b0;
    model_reset();
    cyc(1, 1, 0, 32'h0);
    ip_rst_n = 1'b1;
    repeat (5) cyc(0, 1, 0, 32'h0);
    chk("stall_addr", bus.op_inst_addr, 32'h8);
    repeat (4) cyc(1, 1, 0, 32'h0);

    // Redirect while full with a simultaneous pop.
    repeat (3) cyc(0, 1, 0, 32'h0);
    cyc(1, 1, 1, 32'h100);
    repeat (4) cyc(1, 1, 0, 32'h0);

    // imem not valid mid-stream.
    repeat (3) cyc(1, 0, 0, 32'h0);
    repeat (4) cyc(1, 1, 0, 32'h0);

    // Misaligned redirects, then aligned recovery.
    cyc(1, 1, 1, 32'h102);
    repeat (3) cyc(1, 1, 0, 32'h0);
    cyc(1, 1, 1, 32'h107);
    repeat (2) cyc(1, 1, 0, 32'h0);
    cyc(1, 1, 1, 32'h200);
    repeat (4) cyc(1, 1, 0, 32'h0);

    // PC wrap past 2^32.
    cyc(1, 1, 1, 32'hFFFF_FFF8);
    repeat (5) cyc(1, 1, 0, 32'h0);

    repeat (400) begin
      rdy   = ($urandom_range(0, 3) != 0);
      ivld  = ($urandom_range(0, 4) != 0);
      redir = ($urandom_range(0, 99) < 5);
      tgt   = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      cyc(rdy, ivld, redir, tgt);
    end

    // Asynchronous reset with a full buffer.
    cyc(1, 1, 1, 32'h300);
    repeat (4) cyc(0, 1, 0, 32'h0);
    #2;
    ip_rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.op_inst_valid), 32'h0);
    chk("rst_inst", bus.op_inst, NOP_INST);
    chk("rst_pc", bus.op_inst_pc, 32'h0);
    chk("rst_addr", bus.op_inst_addr, RST_PC);
    chk("rst_misalign", 32'(bus.op_fetch_misalign), 32'h0);
    model_reset();
    repeat (2) cyc(1, 1, 0, 32'h0);
    ip_rst_n = 1'b1;
    repeat (6) cyc(1, 1, 0, 32'h0);
    repeat (3) cyc(1, 0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage: owns the program counter, drives the word address into the asynchronous-read instruction memory, and captures the returned instruction words. Each captured word is stored with its PC in a small FIFO that feeds decode through a valid/ready handshake. Branch/jump redirects flush the stage and restart fetch at the target. The stage sits between the PC redirect logic in execute and the instruction memory / decode pair.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- BUF_DEPTH, 2: output FIFO entries; power of two, ≥2.

- ip_clk  in  1  clock, all state on rising edge.
- ip_rst_n  in  1  reset, asynchronous, active-low.
- op_inst_addr  out  32  byte address to instruction memory, equals PC register.
- ip_inst_valid  in  1  instruction memory returned word is valid this cycle.
- ip_inst_from_imem  in  32  instruction word for op_inst_addr, same cycle.
- ip_redirect  in  1  flush and restart fetch at ip_redirect_pc.
- ip_redirect_pc  in  32  redirect target.
- op_inst_valid  out  1  FIFO head valid to decode.
- op_inst  out  32  FIFO head instruction.
- op_inst_pc  out  32  FIFO head PC.
- ip_dec_ready  in  1  decode accepts head this cycle.
- op_fetch_misalign  out  1  misaligned redirect trap flag; tied 0 without the macro.

## Operation
- Reset values: PC=RESET_PC, FIFO empty, op_inst_valid=0, op_inst=32'h0000_0013 (NOP), op_inst_pc=0, op_fetch_misalign=0, state RUN.
- Pop = op_inst_valid & ip_dec_ready.
- Fetch fires when state==RUN, no redirect, ip_inst_valid=1, and (count<BUF_DEPTH or pop). On fire: push {PC, ip_inst_from_imem}, PC<=PC+4, wrapping modulo 2^32.
- Full with no pop: no push, PC holds, imem keeps seeing the same address.
- Empty FIFO: op_inst_valid=0, op_inst=NOP, op_inst_pc=0.
- Redirect has priority over fetch:
  - FIFO flushed (count=0, pointers=0), PC<=target, no push that cycle.
  - A pop in the same cycle completes normally; the consumed entry belongs to decode.
- FSM states: RUN and TRAP. TRAP exists only with the macro; see Configuration.
- FIFO arithmetic: read/write pointers are log2(BUF_DEPTH) bits and wrap naturally; count is log2(BUF_DEPTH)+1 bits. Push and pop in the same cycle leave count unchanged.
- Reset asserted mid-operation: immediate return to reset values, all FIFO contents discarded.

## Timing
- op_inst_addr is combinational from the PC register. The imem word is captured at the same edge.
- First instruction: op_inst_valid=1 in the first cycle after the first rising edge following reset release.
- Throughput: 1 instruction/cycle with ip_inst_valid and ip_dec_ready held high.
- Redirect sampled at edge N:
  - op_inst_addr=target and op_inst_valid=0 during cycle N+1.
  - Target instruction valid at decode in cycle N+2.
- Back-pressure: with ip_dec_ready=0, at most BUF_DEPTH pushes occur before fetch stalls. Release restarts fetch in the same cycle.

## Configuration
- IFETCH_MISALIGN_TRAP_EN defined:
  - A redirect with target[1:0]≠0 enters TRAP. PC still loads the raw target, FIFO is flushed, and op_fetch_misalign=1 from the next cycle.
  - No fetch occurs in TRAP.
  - Only an aligned redirect returns the stage to RUN and clears the flag.
  - A misaligned redirect while in TRAP stays in TRAP.
- IFETCH_MISALIGN_TRAP_EN undefined:
  - Target[1:0] is forced to 00, the state is always RUN, and op_fetch_misalign=0.

## Structure
- Package fetch_pkg holds the NOP constant 32'h0000_0013, the PC increment constant 4, and the state enum {RUN, TRAP}.
- Sub-module fetch_buf: parameterised synchronous FIFO carrying {pc[31:0], inst[31:0]}, with push, pop, flush, count, and head outputs. The FSM, PC register and fetch enable live in ifetch.

## Test plan
- Reset release, imem returns addr-based words, ip_dec_ready=1 -> decode sees PCs 0,4,8,12 on consecutive cycles, first valid one cycle after release.
- ip_dec_ready=0 for 5 cycles from reset -> exactly 2 pushes and op_inst_addr stuck at 8; on release, PCs 0,4,8 delivered back-to-back.
- Redirect to 0x100 while FIFO holds 2 entries and pop=1 -> the popped entry is consumed, the other is dropped, op_inst_valid=0 for one cycle, then PC 0x100 is valid.
- ip_inst_valid=0 for 3 cycles mid-stream -> no pushes, PC holds, stream resumes with no skipped or duplicated PC.
- Macro on, redirect to 0x102 -> op_fetch_misalign=1, no fetch; then redirect to 0x200 -> flag clears, PC 0x200 delivered. Macro off, same redirect to 0x102 -> fetch continues at 0x100.
- Assert ip_rst_n mid-stream with a full FIFO -> outputs immediately return to reset values (op_inst=0x00000013).
